vga_sync_gen: RTL
=================

// Module: vga_sync_gen
// PURPOSE
//  Raster timing generator for the 640x480@60 display path. Divides the system clock into a
//  pixel tick and runs horizontal/vertical counters. Drives hsync/vsync to the connector and
//  video_on/x/y to the downstream pixel-colour stage (metronome). That stage needs y to reach
//  481 at x==0 exactly once per frame for its refresh tick.
// PARAMETERS
//  CLK_DIV    4    system clocks per pixel; >=1; 1 => p_tick held high
//  H_DISPLAY  640  visible pixels per line
//  H_FRONT    16   horizontal front porch, pixels
//  H_SYNC     96   horizontal sync width, pixels
//  H_BACK     48   horizontal back porch, pixels
//  V_DISPLAY  480  visible lines
//  V_FRONT    10   vertical front porch, lines
//  V_SYNC     2    vertical sync width, lines
//  V_BACK     33   vertical back porch, lines
// PORTS
//  clk       in   1   system clock (100 MHz nominal)
//  reset_n   in   1   reset, asynchronous, active-low
//  p_tick    out  1   one-clk pulse every CLK_DIV clks; all counters advance only on it
//  hsync     out  1   horizontal sync, active-low
//  vsync     out  1   vertical sync, active-low
//  video_on  out  1   high while (x,y) is inside the visible area
//  x         out  10  current pixel column, 0..H_TOTAL-1
//  y         out  10  current line, 0..V_TOTAL-1
// BEHAVIOUR
//  - H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525). Both must fit in 10 bits.
//  - Reset values, applied immediately on reset_n low:
//    divider=0, x=0, y=0, hsync=1, vsync=1, video_on=1 (the decode of (0,0)), p_tick=0.
//  - Divider: counts 0..CLK_DIV-1. p_tick is registered. It is high in the clk after the
//    divider reaches CLK_DIV-1, so the first p_tick comes CLK_DIV clks after reset release.
//  - On p_tick: x <= (x==H_TOTAL-1) ? 0 : x+1.
//    On the x wrap only: y <= (y==V_TOTAL-1) ? 0 : y+1.
//    The simultaneous x and y wrap at (799,524) goes to (0,0).
//  - hsync/vsync/video_on are registered from the next-state counters. Invariant every clk:
//    outputs equal the decode of the current (x,y). No extra latency vs x/y; glitch-free.
//  - hsync = 0 iff H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC (656..751).
//  - vsync = 0 iff V_DISPLAY+V_FRONT <= y < V_DISPLAY+V_FRONT+V_SYNC (490..491).
//  - video_on = (x < H_DISPLAY) && (y < V_DISPLAY).
//  - Between p_ticks, x/y/hsync/vsync/video_on hold their values.
//  - Reset asserted mid-frame: everything returns to the reset values asynchronously.
//    The frame restarts at (0,0) after release, with no partial-line carry-over.
// CONFIGURATION
//  - `VGA_SYNC_FRAME_CNT_EN defined: adds output frame_cnt[7:0] (reset 0).
//    It increments on the p_tick that wraps (799,524)->(0,0) and wraps 255->0.
//  - Macro undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  - Package vga_timing_pkg: H_TOTAL/V_TOTAL and the sync-start/sync-end localparams derived
//    from the default timing, plus the 10-bit coord_t typedef used by all downstream stages.
//  - Sub-module vga_pixel_tick (params CLK_DIV; ports clk, reset_n, p_tick) holds the divider.
//    The counters and decode stay in the top level.
// TESTING
//  1. Release reset, count clks -> first p_tick at clk 4; then exactly every 4 clks;
//     x=y=0, hsync=vsync=1 before it.
//  2. One line -> 800 p_ticks per line; hsync low for exactly x=656..751 (96 ticks);
//     x 799 -> 0 increments y.
//  3. Full frame -> 525 lines = 420000 p_ticks = 1,680,000 clks;
//     vsync low only on y=490,491; (x,y)=(0,481) seen exactly once per frame.
//  4. Visible boundary -> video_on=1 at (639,479), 0 at (640,479), (0,480) and (799,524);
//     1 again at (0,0).
//  5. Assert reset_n at (700,300) for 3 clks -> outputs at reset values without waiting for
//     clk; counting resumes from (0,0).
//  6. With VGA_SYNC_FRAME_CNT_EN -> frame_cnt 0 ->1 at the first frame wrap;
//     preload-style run through 256 frames -> 255 wraps to 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Purpose: default 640x480@60 raster timing constants and the shared coordinate type.
// Latency: none, this file holds constants and types only.
// Backpressure: not applicable.
package vga_timing_pkg;

    // Column/line coordinate carried by every downstream pixel stage.
    typedef logic [9:0] coord_t;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // Sync pulses occupy [start, end) in pixels / lines.
    localparam int H_SYNC_START = H_DISPLAY_DEF + H_FRONT_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
    localparam int V_SYNC_START = V_DISPLAY_DEF + V_FRONT_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

endpackage

// File: rtl/vga_pixel_tick.sv
// Purpose: divides the system clock down to a one-clk pixel tick every CLK_DIV clks.
// Latency: first tick is high in the clk after CLK_DIV rising edges following reset release.
// Backpressure: none, free-running; CLK_DIV == 1 holds the tick high.
module vga_pixel_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic p_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    // Divider wraps at CLK_DIV-1; the tick is registered off that terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div    <= '0;
            p_tick <= 1'b0;
        end else begin
            p_tick <= (div == DIV_LAST);
            div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Purpose: raster timing generator (x/y counters, hsync/vsync/video_on); optional frame counter under VGA_SYNC_FRAME_CNT_EN.
// Latency: sync/video_on are decoded from next-state x/y, so they change on the same edge as x/y.
// Backpressure: none, free-running; state only advances on p_tick and holds otherwise.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       p_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t X_LAST = coord_t'(H_TOT - 1);
    localparam coord_t Y_LAST = coord_t'(V_TOT - 1);

    // 11-bit bounds so a total of exactly 1024 still compares correctly.
    localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);

    coord_t x_nxt;
    coord_t y_nxt;
    logic   hsync_nxt;
    logic   vsync_nxt;
    logic   video_on_nxt;

    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .p_tick  (p_tick)
    );

    // Next raster position: x advances per tick, y only on the x wrap, both wrap to (0,0).
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (p_tick) begin
            if (x == X_LAST) begin
                x_nxt = '0;
                y_nxt = (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x_nxt = x + 1'b1;
            end
        end
    end

    // Decode the next position so the registered outputs line up with x/y exactly.
    always_comb begin
        hsync_nxt    = !(({1'b0, x_nxt} >= HS_START) && ({1'b0, x_nxt} < HS_END));
        vsync_nxt    = !(({1'b0, y_nxt} >= VS_START) && ({1'b0, y_nxt} < VS_END));
        video_on_nxt = ({1'b0, x_nxt} < H_VIS) && ({1'b0, y_nxt} < V_VIS);
    end

    // Position and decoded outputs; reset lands on (0,0) and its decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x        <= '0;
            y        <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b1;
        end else begin
            x        <= x_nxt;
            y        <= y_nxt;
            hsync    <= hsync_nxt;
            vsync    <= vsync_nxt;
            video_on <= video_on_nxt;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    // Frame counter bumps on the tick that wraps the last pixel of the frame; rolls over at 255.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= 8'd0;
        end else if (p_tick && (x == X_LAST) && (y == Y_LAST)) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule
